// File: rtl/tile_sched_ctrl_pkg.sv
// Shared definitions for the tile scheduler controller.
// Holds the default parameter widths and the sequencer state encoding
// used by tile_sched_ctrl and its launcher sub-module.
package tile_sched_ctrl_pkg;

    localparam int unsigned DEF_NUM_TAGS = 2;
    localparam int unsigned DEF_TILE_W   = 16;
    localparam int unsigned DEF_REUSE_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } sched_state_e;

endpackage

// File: rtl/tile_sched_ctrl_sched_launcher.sv
// sched_launcher: one engine launcher (load, compute or store).
// Pulses start_o when the engine's tag is available, the engine is idle
// and fewer than limit_i starts have been issued; tracks the busy flag
// and the issue count, and reports when the count reaches target_i.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   clear_i        - job acceptance; zeroes the issue count and busy flag
//   en_i           - a job is in flight
//   tag_ready_i    - engine tag available
//   done_i         - engine completion pulse
//   limit_i        - issue allowed while issued < limit_i
//   target_i       - total issues expected for the job
//   start_o        - one-cycle engine launch pulse
//   tag_done_o     - done_i qualified by busy (stray dones are dropped)
//   busy_o         - engine running
//   at_target_o    - issue count equals target_i
module sched_launcher #(
    parameter int unsigned CNT_W = 19
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic             tag_ready_i,
    input  logic             done_i,
    input  logic [CNT_W-1:0] limit_i,
    input  logic [CNT_W-1:0] target_i,
    output logic             start_o,
    output logic             tag_done_o,
    output logic             busy_o,
    output logic             at_target_o
);

    logic             busy_q;
    logic             busy_d;
    logic [CNT_W-1:0] issued_q;
    logic [CNT_W-1:0] issued_d;

    // Requiring !busy_q means start can never coincide with a counted done.
    assign start_o     = en_i && tag_ready_i && !busy_q && (issued_q < limit_i);
    assign tag_done_o  = done_i && busy_q;
    assign busy_o      = busy_q;
    assign at_target_o = (issued_q == target_i);

    // Next-state for the busy flag and issue counter.
    always_comb begin
        busy_d   = busy_q;
        issued_d = issued_q;
        if (clear_i) begin
            busy_d   = 1'b0;
            issued_d = {CNT_W{1'b0}};
        end else if (start_o) begin
            busy_d   = 1'b1;
            issued_d = issued_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (tag_done_o) begin
            busy_d   = 1'b0;
        end else begin
            busy_d   = busy_q;
        end
    end

    // Launcher state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q   <= 1'b0;
            issued_q <= {CNT_W{1'b0}};
        end else begin
            busy_q   <= busy_d;
            issued_q <= issued_d;
        end
    end

endmodule

// File: rtl/tile_sched_ctrl.sv
// tile_sched_ctrl: double-buffered tile scheduling controller.
// Accepts a job (tile count, passes per tile, store enable), requests one
// tag per (tile, pass) from the tag synchronizer in tile-major order, then
// flushes and drains. Three launchers issue load / compute / store starts
// concurrently with the sequencer.
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   cfg_*                       - job request handshake and configuration
//   busy, job_done              - status and one-cycle completion pulse
//   tag_req/tag_reuse/block_done, tag_ready/tag_done - tag synchronizer
//   *_tag_ready, *_tag_done     - per-engine tag availability / release
//   *_start, *_done             - engine launch and completion pulses
module tile_sched_ctrl
    import tile_sched_ctrl_pkg::*;
#(
    parameter int unsigned NUM_TAGS = DEF_NUM_TAGS,
    parameter int unsigned TILE_W   = DEF_TILE_W,
    parameter int unsigned REUSE_W  = DEF_REUSE_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [TILE_W-1:0]  cfg_num_tiles,
    input  logic [REUSE_W-1:0] cfg_passes,
    input  logic               cfg_store_en,
    output logic               busy,
    output logic               job_done,
    output logic               tag_req,
    output logic               tag_reuse,
    output logic               block_done,
    input  logic               tag_ready,
    input  logic               tag_done,
    input  logic               ldmem_tag_ready,
    input  logic               compute_tag_ready,
    input  logic               stmem_tag_ready,
    output logic               ld_start,
    output logic               cp_start,
    output logic               st_start,
    input  logic               ld_done,
    input  logic               cp_done,
    input  logic               st_done,
    output logic               ldmem_tag_done,
    output logic               compute_tag_done,
    output logic               stmem_tag_done
);

    localparam int unsigned CNT_W = TILE_W + REUSE_W;

    // Tag rotation lives in the external synchronizer; the controller only
    // sequences requests, so the tag count does not shape any logic here.
    if (NUM_TAGS == 0) begin : g_no_tags
    end

    sched_state_e       state_q, state_d;
    logic [TILE_W-1:0]  num_tiles_q, num_tiles_d;
    logic [REUSE_W-1:0] passes_q, passes_d;
    logic               store_en_q, store_en_d;
    logic [TILE_W-1:0]  tile_q, tile_d;
    logic [REUSE_W-1:0] pass_q, pass_d;
    logic [CNT_W-1:0]   grants_q, grants_d;
    logic               job_done_q, job_done_d;

    logic               accept_s;
    logic               active_s;
    logic               drain_ok_s;
    logic [CNT_W-1:0]   ld_target_s, cp_target_s, st_target_s;
    logic               ld_busy_s, cp_busy_s, st_busy_s;
    logic               ld_at_s, cp_at_s, st_at_s;

    assign accept_s    = cfg_valid && (state_q == ST_IDLE);
    assign active_s    = (state_q != ST_IDLE);
    assign ld_target_s = CNT_W'(num_tiles_q);
    assign cp_target_s = CNT_W'(num_tiles_q) * CNT_W'(passes_q);
    assign st_target_s = store_en_q ? CNT_W'(num_tiles_q) : {CNT_W{1'b0}};
    assign drain_ok_s  = tag_done && !ld_busy_s && !cp_busy_s && !st_busy_s
                         && ld_at_s && cp_at_s && st_at_s;

    assign cfg_ready  = (state_q == ST_IDLE);
    assign busy       = active_s;
    assign job_done   = job_done_q;
    assign tag_req    = (state_q == ST_REQ);
    assign tag_reuse  = (state_q == ST_REQ) && (pass_q != {REUSE_W{1'b0}});
    assign block_done = (state_q == ST_FLUSH);

    // Sequencer next-state: job latch, (tile, pass) walk, flush and drain.
    always_comb begin
        state_d     = state_q;
        num_tiles_d = num_tiles_q;
        passes_d    = passes_q;
        store_en_d  = store_en_q;
        tile_d      = tile_q;
        pass_d      = pass_q;
        grants_d    = grants_q;
        job_done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    num_tiles_d = cfg_num_tiles;
                    // Zero passes means one pass.
                    passes_d    = (cfg_passes == {REUSE_W{1'b0}}) ?
                                  {{(REUSE_W-1){1'b0}}, 1'b1} : cfg_passes;
                    store_en_d  = cfg_store_en;
                    tile_d      = {TILE_W{1'b0}};
                    pass_d      = {REUSE_W{1'b0}};
                    grants_d    = {CNT_W{1'b0}};
                    // An empty job completes without touching the synchronizer.
                    if (cfg_num_tiles == {TILE_W{1'b0}}) begin
                        job_done_d = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (tag_ready) begin
                    grants_d = grants_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (pass_q == passes_q - {{(REUSE_W-1){1'b0}}, 1'b1}) begin
                        pass_d = {REUSE_W{1'b0}};
                        if (tile_q == num_tiles_q - {{(TILE_W-1){1'b0}}, 1'b1}) begin
                            state_d = ST_FLUSH;
                        end else begin
                            tile_d = tile_q + {{(TILE_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        pass_d = pass_q + {{(REUSE_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_FLUSH: begin
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_ok_s) begin
                    state_d    = ST_IDLE;
                    job_done_d = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            num_tiles_q <= {TILE_W{1'b0}};
            passes_q    <= {REUSE_W{1'b0}};
            store_en_q  <= 1'b0;
            tile_q      <= {TILE_W{1'b0}};
            pass_q      <= {REUSE_W{1'b0}};
            grants_q    <= {CNT_W{1'b0}};
            job_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_tiles_q <= num_tiles_d;
            passes_q    <= passes_d;
            store_en_q  <= store_en_d;
            tile_q      <= tile_d;
            pass_q      <= pass_d;
            grants_q    <= grants_d;
            job_done_q  <= job_done_d;
        end
    end

    sched_launcher #(.CNT_W(CNT_W)) u_ld_launch (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (accept_s),
        .en_i        (active_s),
        .tag_ready_i (ldmem_tag_ready),
        .done_i      (ld_done),
        .limit_i     (ld_target_s),
        .target_i    (ld_target_s),
        .start_o     (ld_start),
        .tag_done_o  (ldmem_tag_done),
        .busy_o      (ld_busy_s),
        .at_target_o (ld_at_s)
    );

    // Compute may only run on tags already granted.
    sched_launcher #(.CNT_W(CNT_W)) u_cp_launch (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (accept_s),
        .en_i        (active_s),
        .tag_ready_i (compute_tag_ready),
        .done_i      (cp_done),
        .limit_i     (grants_q),
        .target_i    (cp_target_s),
        .start_o     (cp_start),
        .tag_done_o  (compute_tag_done),
        .busy_o      (cp_busy_s),
        .at_target_o (cp_at_s)
    );

    sched_launcher #(.CNT_W(CNT_W)) u_st_launch (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (accept_s),
        .en_i        (active_s),
        .tag_ready_i (stmem_tag_ready),
        .done_i      (st_done),
        .limit_i     (st_target_s),
        .target_i    (st_target_s),
        .start_o     (st_start),
        .tag_done_o  (stmem_tag_done),
        .busy_o      (st_busy_s),
        .at_target_o (st_at_s)
    );

endmodule
